// File: rtl/cpu_ex_pkg.sv
// Shared types and widths for the CPU external-port loader.
// Op encodings, FSM states and the burst-length decode helper.
package cpu_ex_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {IM_WR = 2'd0, MEM_WR = 2'd1, MEM_RD = 2'd2, OP_RSVD = 2'd3} ex_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} ex_state_t;

  // A length field of zero means a full 256-word burst.
  function automatic logic [LEN_W:0] len_decode(input logic [LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  endfunction

endpackage

// File: rtl/cpu_ex_loader_if.sv
// Host-side bus of the loader: command, write-data and read-response streams plus status.
// master = host/MMIO side, slave = loader.
interface cpu_ex_loader_if;
  import cpu_ex_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready,
    input  cmd_ready, wdata_ready, rsp_valid, rsp_data, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready,
    output cmd_ready, wdata_ready, rsp_valid, rsp_data, busy, err
  );

endinterface

// File: rtl/cpu_ex_rsp_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; data valid whenever valid=1, 1-cycle push-to-valid.
// Backpressure: pushes when full are dropped (caller reserves credits); pops only when non-empty.
module cpu_ex_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign valid    = (count != '0);
  assign do_pop   = pop && valid;
  assign do_push  = push && (count != CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ex_loader.sv
// Burst loader driving the CPU ex_ port; strobes 1 cycle after each wdata/issue, read words reach rsp 2 cycles after issue.
// Backpressure: reads issue only while outstanding+buffered < RSP_DEPTH; commands wait for an empty response FIFO.
module cpu_ex_loader
  import cpu_ex_pkg::*;
#(
  parameter int RSP_DEPTH  = 4,
  parameter int IM_STRIDE  = 4,
  parameter int MEM_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_ex_loader_if.slave    host,
  output logic              ex_im_wrt_en,
  output logic              ex_mem_wrt_en,
  output logic              ex_mem_rd_en,
  output logic [ADDR_W-1:0] ex_addr,
  output logic [DATA_W-1:0] ex_wrt_data,
  input  logic [DATA_W-1:0] ex_rd_data,
  input  logic              ex_rd_valid
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_READ  = READ;

  localparam logic [ADDR_W-1:0] IM_INC  = ADDR_W'(IM_STRIDE);
  localparam logic [ADDR_W-1:0] MEM_INC = ADDR_W'(MEM_STRIDE);

  logic [1:0]        state, op;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W:0]    left;          // words still to accept (WRITE) or issue (READ)
  logic [CW-1:0]     outstanding, fifo_count;
  logic [CW:0]       credit_used;
  logic              err_q, fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              cmd_fire, wr_fire, rd_issue, rd_ret, rsp_pop;

  assign host.cmd_ready   = (state == S_IDLE) && (fifo_count == '0);
  assign host.wdata_ready = (state == S_WRITE);
  assign host.busy        = (state != S_IDLE);
  assign host.err         = err_q;
  assign host.rsp_valid   = fifo_valid;
  assign host.rsp_data    = fifo_data;

  assign cmd_fire    = host.cmd_valid && host.cmd_ready;
  assign wr_fire     = host.wdata_valid && host.wdata_ready;
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign rd_issue    = (state == S_READ) && (left != '0) && (credit_used < (CW+1)'(RSP_DEPTH));
  // A response with nothing outstanding is flagged as an error and dropped, never buffered.
  assign rd_ret      = ex_rd_valid && (outstanding != '0);
  assign rsp_pop     = fifo_valid && host.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      op            <= '0;
      cur_addr      <= '0;
      left          <= '0;
      outstanding   <= '0;
      err_q         <= 1'b0;
      ex_im_wrt_en  <= 1'b0;
      ex_mem_wrt_en <= 1'b0;
      ex_mem_rd_en  <= 1'b0;
      ex_addr       <= '0;
      ex_wrt_data   <= '0;
    end else begin
      ex_im_wrt_en  <= 1'b0;
      ex_mem_wrt_en <= 1'b0;
      ex_mem_rd_en  <= 1'b0;
      if (ex_rd_valid && outstanding == '0) err_q <= 1'b1;

      case (state)
        S_IDLE: if (cmd_fire) begin
          op       <= host.cmd_op;
          cur_addr <= host.cmd_addr;
          left     <= len_decode(host.cmd_len);
          case (host.cmd_op)
            IM_WR, MEM_WR: state <= S_WRITE;
            MEM_RD:        state <= S_READ;
            default:       err_q <= 1'b1;
          endcase
        end
        S_WRITE: if (wr_fire) begin
          ex_im_wrt_en  <= (op == IM_WR);
          ex_mem_wrt_en <= (op == MEM_WR);
          ex_addr       <= cur_addr;
          ex_wrt_data   <= host.wdata;
          cur_addr      <= cur_addr + ((op == IM_WR) ? IM_INC : MEM_INC);
          left          <= left - (LEN_W+1)'(1);
          if (left == (LEN_W+1)'(1)) state <= S_IDLE;
        end
        S_READ: begin
          if (rd_issue) begin
            ex_mem_rd_en <= 1'b1;
            ex_addr      <= cur_addr;
            cur_addr     <= cur_addr + MEM_INC;
            left         <= left - (LEN_W+1)'(1);
          end
          // outstanding drops on the same edge as the final push, so zero here means it landed.
          if (left == '0 && outstanding == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      case ({rd_issue, rd_ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  cpu_ex_rsp_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_ret),
    .push_data (ex_rd_data),
    .pop       (rsp_pop),
    .pop_data  (fifo_data),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

endmodule
